// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 core control logic.
package aes_pkg;

    // Round sequencer states: idle, key/data load, cipher rounds, result held.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } aes_rnd_state_t;

    // AES-128 performs ten rounds after the initial AddRoundKey.
    localparam int AES128_NROUNDS = 10;

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 core: drives key-schedule strobes, the
// round index and first/last markers, and holds done until acknowledged.
// Every output is decoded purely from the state and round registers, so no
// input ever reaches an output combinationally.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NROUNDS = AES128_NROUNDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       ack_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       kld_o,
    output logic       knxt_o,
    output logic       dat_ld_o,
    output logic [3:0] rnd_o,
    output logic       first_rnd_o,
    output logic       last_rnd_o,
    output logic       done_o
);

    // Index of the final round; the counter never goes beyond this value.
    localparam logic [3:0] LP_LAST_RND = 4'(NROUNDS);

    aes_rnd_state_t r_state;
    logic [3:0]     r_rnd;

    // State and round-counter update; abort overrides every other transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rnd   <= 4'd0;
        end else if (abort_i) begin
            r_state <= IDLE;
            r_rnd   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= LOAD;
                        r_rnd   <= 4'd0;
                    end
                end
                LOAD: begin
                    r_state <= ROUND;
                    r_rnd   <= 4'd1;
                end
                ROUND: begin
                    if (r_rnd == LP_LAST_RND) begin
                        // Hold the index at the final round while done is shown.
                        r_state <= DONE;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                DONE: begin
                    // A start seen here is dropped, even alongside ack.
                    if (ack_i) begin
                        r_state <= IDLE;
                        r_rnd   <= 4'd0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rnd   <= 4'd0;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        ready_o     = (r_state == IDLE);
        busy_o      = (r_state == LOAD) || (r_state == ROUND);
        kld_o       = (r_state == LOAD);
        dat_ld_o    = (r_state == LOAD);
        knxt_o      = (r_state == ROUND);
        rnd_o       = r_rnd;
        first_rnd_o = (r_state == ROUND) && (r_rnd == 4'd1);
        last_rnd_o  = (r_state == ROUND) && (r_rnd == LP_LAST_RND);
        done_o      = (r_state == DONE);
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: default ten-round instance plus a
// single-round instance. Outputs are packed as
// {ready, busy, kld, knxt, dat_ld, rnd[3:0], first, last, done}.
module tb_aes_round_ctrl;

    logic       clk;
    logic       rst;
    logic       start_i, abort_i, ack_i;
    logic       ready_o, busy_o, kld_o, knxt_o, dat_ld_o;
    logic [3:0] rnd_o;
    logic       first_rnd_o, last_rnd_o, done_o;

    logic       start1, abort1, ack1;
    logic       ready1, busy1, kld1, knxt1, dat_ld1;
    logic [3:0] rnd1;
    logic       first1, last1, done1;

    logic [11:0] obs, obs1, exp_v;
    int n_pass  = 0;
    int n_total = 0;

    assign obs  = {ready_o, busy_o, kld_o, knxt_o, dat_ld_o, rnd_o, first_rnd_o, last_rnd_o, done_o};
    assign obs1 = {ready1, busy1, kld1, knxt1, dat_ld1, rnd1, first1, last1, done1};

    aes_round_ctrl #(.NROUNDS(10)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .ack_i(ack_i),
        .ready_o(ready_o), .busy_o(busy_o), .kld_o(kld_o), .knxt_o(knxt_o),
        .dat_ld_o(dat_ld_o), .rnd_o(rnd_o), .first_rnd_o(first_rnd_o),
        .last_rnd_o(last_rnd_o), .done_o(done_o)
    );

    aes_round_ctrl #(.NROUNDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .abort_i(abort1), .ack_i(ack1),
        .ready_o(ready1), .busy_o(busy1), .kld_o(kld1), .knxt_o(knxt1),
        .dat_ld_o(dat_ld1), .rnd_o(rnd1), .first_rnd_o(first1),
        .last_rnd_o(last1), .done_o(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-vector builders for each state.
    function automatic logic [11:0] e_idle();
        return 12'b1_0_0_0_0_0000_0_0_0;
    endfunction
    function automatic logic [11:0] e_load();
        return 12'b0_1_1_0_1_0000_0_0_0;
    endfunction
    function automatic logic [11:0] e_round(input logic [3:0] r, input logic [3:0] n);
        return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, r, (r == 4'd1), (r == n), 1'b0};
    endfunction
    function automatic logic [11:0] e_done(input logic [3:0] n);
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n, 1'b0, 1'b0, 1'b1};
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 0; abort_i = 0; ack_i = 0;
        start1 = 0; abort1 = 0; ack1 = 0;
        #2;
        exp_v = e_idle();
        if (obs !== exp_v) $display("FAIL reset_during: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        if (obs1 !== exp_v) $display("FAIL reset_during_n1: got %b expected %b", obs1, exp_v);
        else n_pass++;
        n_total++;
        step(); step();
        rst = 1'b0;
        step();
        if (obs !== exp_v) $display("FAIL reset_after: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        $display("reset: done");
    endtask

    task automatic test_basic();
        ack_i = 1; start_i = 1;
        step();
        start_i = 0;
        exp_v = e_load();
        if (obs !== exp_v) $display("FAIL basic_load: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        for (int r = 1; r <= 10; r++) begin
            step();
            exp_v = e_round(4'(r), 4'd10);
            if (obs !== exp_v) $display("FAIL basic_round%0d: got %b expected %b", r, obs, exp_v);
            else n_pass++;
            n_total++;
        end
        step();
        exp_v = e_done(4'd10);
        if (obs !== exp_v) $display("FAIL basic_done: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        step();
        exp_v = e_idle();
        if (obs !== exp_v) $display("FAIL basic_idle: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        $display("basic: one op complete");
    endtask

    task automatic test_held_done();
        ack_i = 0; start_i = 1;
        step();
        start_i = 0;
        exp_v = e_load();
        if (obs !== exp_v) $display("FAIL held_load: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        for (int r = 1; r <= 10; r++) begin
            step();
            exp_v = e_round(4'(r), 4'd10);
            if (obs !== exp_v) $display("FAIL held_round%0d: got %b expected %b", r, obs, exp_v);
            else n_pass++;
            n_total++;
        end
        for (int k = 0; k < 5; k++) begin
            step();
            exp_v = e_done(4'd10);
            if (obs !== exp_v) $display("FAIL held_done%0d: got %b expected %b", k, obs, exp_v);
            else n_pass++;
            n_total++;
            start_i = (k == 2);
        end
        ack_i = 1; start_i = 1;
        step();
        ack_i = 0; start_i = 0;
        exp_v = e_idle();
        if (obs !== exp_v) $display("FAIL held_ack_with_start: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        step();
        if (obs !== exp_v) $display("FAIL held_not_queued: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        $display("held_done: done held 5 cycles then acked");
    endtask

    task automatic test_abort();
        ack_i = 1; start_i = 1;
        step();
        start_i = 0;
        for (int r = 1; r <= 4; r++) begin
            step();
            exp_v = e_round(4'(r), 4'd10);
            if (obs !== exp_v) $display("FAIL abort_pre_round%0d: got %b expected %b", r, obs, exp_v);
            else n_pass++;
            n_total++;
        end
        abort_i = 1;
        step();
        abort_i = 0;
        exp_v = e_idle();
        for (int k = 0; k < 4; k++) begin
            if (obs !== exp_v) $display("FAIL abort_idle%0d: got %b expected %b", k, obs, exp_v);
            else n_pass++;
            n_total++;
            step();
        end
        // Immediate restart must run a complete sequence.
        start_i = 1;
        step();
        start_i = 0;
        exp_v = e_load();
        if (obs !== exp_v) $display("FAIL abort_restart_load: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        for (int r = 1; r <= 10; r++) begin
            step();
            exp_v = e_round(4'(r), 4'd10);
            if (obs !== exp_v) $display("FAIL abort_restart_round%0d: got %b expected %b", r, obs, exp_v);
            else n_pass++;
            n_total++;
        end
        ack_i = 0;
        step();
        exp_v = e_done(4'd10);
        if (obs !== exp_v) $display("FAIL abort_restart_done: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        // Abort while done is held drops done.
        abort_i = 1;
        step();
        abort_i = 0;
        exp_v = e_idle();
        if (obs !== exp_v) $display("FAIL abort_in_done: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        step();
        if (obs !== exp_v) $display("FAIL abort_in_done_after: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        $display("abort: mid-round and in-done aborts applied");
    endtask

    task automatic test_async_reset();
        ack_i = 1; start_i = 1;
        step();
        start_i = 0;
        for (int r = 1; r <= 7; r++) begin
            step();
            exp_v = e_round(4'(r), 4'd10);
            if (obs !== exp_v) $display("FAIL async_round%0d: got %b expected %b", r, obs, exp_v);
            else n_pass++;
            n_total++;
        end
        #2;
        rst = 1'b1;
        #1;
        exp_v = e_idle();
        if (obs !== exp_v) $display("FAIL async_immediate: got %b expected %b", obs, exp_v);
        else n_pass++;
        n_total++;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (obs !== exp_v) $display("FAIL async_release%0d: got %b expected %b", k, obs, exp_v);
            else n_pass++;
            n_total++;
        end
        $display("async_reset: mid-round reset applied");
    endtask

    task automatic test_back_to_back();
        int kld_cnt = 0;
        int knxt_cnt = 0;
        int kld_idx[2];
        int ph;
        kld_idx[0] = -1;
        kld_idx[1] = -1;
        ack_i = 1; start_i = 1;
        for (int i = 0; i < 26; i++) begin
            step();
            if (i == 13) start_i = 0;
            ph = i % 13;
            if (ph == 0)       exp_v = e_load();
            else if (ph <= 10) exp_v = e_round(4'(ph), 4'd10);
            else if (ph == 11) exp_v = e_done(4'd10);
            else               exp_v = e_idle();
            if (obs !== exp_v) $display("FAIL b2b_cycle%0d: got %b expected %b", i, obs, exp_v);
            else n_pass++;
            n_total++;
            if (kld_o) begin
                if (kld_cnt < 2) kld_idx[kld_cnt] = i;
                kld_cnt++;
            end
            if (knxt_o) knxt_cnt++;
        end
        if (kld_cnt !== 2) $display("FAIL b2b_kld_count: got %0d expected 2", kld_cnt);
        else n_pass++;
        n_total++;
        if (knxt_cnt !== 20) $display("FAIL b2b_knxt_count: got %0d expected 20", knxt_cnt);
        else n_pass++;
        n_total++;
        if (kld_idx[1] - kld_idx[0] !== 13)
            $display("FAIL b2b_spacing: got %0d expected 13", kld_idx[1] - kld_idx[0]);
        else n_pass++;
        n_total++;
        $display("back_to_back: kld=%0d knxt=%0d spacing=%0d", kld_cnt, knxt_cnt, kld_idx[1] - kld_idx[0]);
    endtask

    task automatic test_param();
        ack1 = 1; start1 = 1;
        step();
        start1 = 0;
        exp_v = e_load();
        if (obs1 !== exp_v) $display("FAIL n1_load: got %b expected %b", obs1, exp_v);
        else n_pass++;
        n_total++;
        step();
        exp_v = 12'b0_1_0_1_0_0001_1_1_0;
        if (obs1 !== exp_v) $display("FAIL n1_round: got %b expected %b", obs1, exp_v);
        else n_pass++;
        n_total++;
        step();
        exp_v = e_done(4'd1);
        if (obs1 !== exp_v) $display("FAIL n1_done: got %b expected %b", obs1, exp_v);
        else n_pass++;
        n_total++;
        step();
        exp_v = e_idle();
        if (obs1 !== exp_v) $display("FAIL n1_idle: got %b expected %b", obs1, exp_v);
        else n_pass++;
        n_total++;
        ack1 = 0;
        $display("param: NROUNDS=1 op complete");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_done();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_param();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
